// File: rtl/bcrypt_loader.sv
// rtl/bcrypt_loader.sv - UART frame loader for the bcrypt hash core
// Collects header/salt/key/cost, then issues load_en and start pulses.
module bcrypt_loader #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         MIN_COST    = 4
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  input  logic         core_done,
  output logic [575:0] salt_c,
  output logic [575:0] key_c,
  output logic [4:0]   cost,
  output logic         load_en,
  output logic         start,
  output logic         frame_err,
  output logic         busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SALT  = 3'd1,
    KEY   = 3'd2,
    COST  = 3'd3,
    LOAD  = 3'd4,
    START = 3'd5,
    RUN   = 3'd6
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [6:0]      byte_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [127:0]    salt_buf;
  logic [575:0]    key_buf;
  logic            xfer;
  logic            receiving;
  logic            tmo_hit;
  logic            cost_ok;
  logic            load_nx;
  logic            start_nx;
  logic            err_nx;

  assign receiving = (state == IDLE) || (state == SALT) || (state == KEY) || (state == COST);
  assign rx_ready  = receiving;
  assign busy      = (state == LOAD) || (state == START) || (state == RUN);
  assign xfer      = rx_valid && rx_ready;
  // An accepted byte on the expiring cycle wins over the timeout.
  assign tmo_hit   = !xfer && (tmo_cnt >= TW'(TIMEOUT_CYC - 1));
  assign cost_ok   = (rx_data >= 8'(MIN_COST)) && (rx_data <= 8'd31);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state     <= IDLE;
      load_en   <= 1'b0;
      start     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      load_en   <= load_nx;
      start     <= start_nx;
      frame_err <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load_nx  = 1'b0;
    start_nx = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (rx_data == HEADER) state_nx = SALT;
          else                   err_nx   = 1'b1;
        end
      end
      SALT: begin
        if (xfer) begin
          if (byte_cnt == 7'd15) state_nx = KEY;
        end else if (tmo_hit) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      KEY: begin
        if (xfer) begin
          if (byte_cnt == 7'd71) state_nx = COST;
        end else if (tmo_hit) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      COST: begin
        if (xfer) begin
          if (cost_ok) begin
            load_nx  = 1'b1;
            state_nx = LOAD;
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end else if (tmo_hit) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      LOAD: begin
        start_nx = 1'b1;
        state_nx = START;
      end
      START: state_nx = RUN;
      RUN: begin
        if (core_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      byte_cnt <= '0;
      tmo_cnt  <= '0;
      salt_buf <= '0;
      key_buf  <= '0;
      salt_c   <= '0;
      key_c    <= '0;
      cost     <= '0;
    end else begin
      if (state_nx != state)  byte_cnt <= '0;
      else if (xfer)          byte_cnt <= byte_cnt + 7'd1;

      if ((state_nx != state) || xfer || (state == IDLE) || !receiving)
        tmo_cnt <= '0;
      else if (tmo_cnt < TW'(TIMEOUT_CYC))
        tmo_cnt <= tmo_cnt + TW'(1);

      // Partial frames never survive a return to IDLE.
      if (state == IDLE) begin
        salt_buf <= '0;
        key_buf  <= '0;
      end else begin
        if (state == SALT && xfer) salt_buf <= {salt_buf[119:0], rx_data};
        if (state == KEY && xfer)  key_buf  <= {key_buf[567:0], rx_data};
      end

      if (load_nx) begin
        salt_c <= {salt_buf, salt_buf, salt_buf, salt_buf, salt_buf[127:64]};
        key_c  <= key_buf;
        cost   <= rx_data[4:0];
      end
    end
  end

endmodule

// File: tb/tb_bcrypt_loader.sv
// tb/tb_bcrypt_loader.sv - directed self-checking bench for bcrypt_loader
module tb_bcrypt_loader;

  logic         clk = 1'b0;
  logic         reset_l;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         core_done;
  logic [575:0] salt_c;
  logic [575:0] key_c;
  logic [4:0]   cost;
  logic         load_en;
  logic         start;
  logic         frame_err;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int n_load = 0, n_start = 0, n_err = 0, n_overlap = 0;

  logic [127:0] fa_salt, fb_salt;
  logic [575:0] fa_key, fb_key;

  always #5 clk = ~clk;

  bcrypt_loader #(.HEADER(8'hA5), .TIMEOUT_CYC(8), .MIN_COST(4)) dut (
    .clk(clk), .reset_l(reset_l), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .core_done(core_done), .salt_c(salt_c), .key_c(key_c),
    .cost(cost), .load_en(load_en), .start(start), .frame_err(frame_err), .busy(busy)
  );

  always @(negedge clk) begin
    if (load_en)   n_load  <= n_load + 1;
    if (start)     n_start <= n_start + 1;
    if (frame_err) n_err   <= n_err + 1;
    if (32'(load_en) + 32'(start) + 32'(frame_err) > 1) n_overlap <= n_overlap + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [575:0] rep_salt(input logic [127:0] s);
    return {s, s, s, s, s[127:64]};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_body(input logic [127:0] s, input logic [575:0] k, input logic [7:0] c);
    for (int i = 0; i < 16; i++) send_byte(s[127-8*i -: 8]);
    for (int i = 0; i < 72; i++) send_byte(k[575-8*i -: 8]);
    send_byte(c);
  endtask

  task automatic send_frame(input logic [127:0] s, input logic [575:0] k, input logic [7:0] c);
    send_byte(8'hA5);
    send_body(s, k, c);
  endtask

  // Called in LOAD: step through START and end RUN with a core_done pulse.
  task automatic finish_run();
    @(posedge clk); #1;
    @(posedge clk); #1;
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_l = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; core_done = 1'b0;
    #3;
    total++; if (rx_ready !== 1'b1) begin $display("FAIL reset_rx_ready: got %b want 1", rx_ready); bad++; end
    total++; if (salt_c !== '0 || key_c !== '0) begin $display("FAIL reset_salt_key: got %h %h want 0", salt_c, key_c); bad++; end
    total++; if (cost !== 5'd0) begin $display("FAIL reset_cost: got %0d want 0", cost); bad++; end
    total++; if ({load_en, start, frame_err, busy} !== 4'b0000) begin $display("FAIL reset_pulses: got %b want 0000", {load_en, start, frame_err, busy}); bad++; end
    @(negedge clk);
    reset_l = 1'b1;
  endtask

  task automatic test_good_frame();
    int l0, s0;
    l0 = n_load; s0 = n_start;
    send_frame(fa_salt, fa_key, 8'h0A);
    total++; if ({load_en, start, busy} !== 3'b101) begin $display("FAIL good_load_cycle: got %b want 101", {load_en, start, busy}); bad++; end
    total++; if (salt_c[575:448] !== 128'h000102030405060708090A0B0C0D0E0F) begin $display("FAIL good_salt_hi: got %h want 000102..0F", salt_c[575:448]); bad++; end
    total++; if (salt_c[63:0] !== 64'h0001020304050607) begin $display("FAIL good_salt_lo: got %h want 0001020304050607", salt_c[63:0]); bad++; end
    total++; if (key_c[575:568] !== 8'h10 || key_c[7:0] !== 8'h57) begin $display("FAIL good_key_ends: got %h %h want 10 57", key_c[575:568], key_c[7:0]); bad++; end
    total++; if (key_c !== fa_key) begin $display("FAIL good_key: got %h want %h", key_c, fa_key); bad++; end
    total++; if (cost !== 5'd10) begin $display("FAIL good_cost: got %0d want 10", cost); bad++; end
    @(posedge clk); #1;
    total++; if ({load_en, start, busy} !== 3'b011) begin $display("FAIL good_start_cycle: got %b want 011", {load_en, start, busy}); bad++; end
    @(posedge clk); #1;
    total++; if ({start, busy, rx_ready} !== 3'b010) begin $display("FAIL good_run: got %b want 010", {start, busy, rx_ready}); bad++; end
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    total++; if ({busy, rx_ready} !== 2'b01) begin $display("FAIL good_done: got %b want 01", {busy, rx_ready}); bad++; end
    total++; if (n_load - l0 !== 1 || n_start - s0 !== 1) begin $display("FAIL good_pulse_count: got %0d %0d want 1 1", n_load - l0, n_start - s0); bad++; end
  endtask

  task automatic test_bad_cost();
    int e0, l0;
    e0 = n_err; l0 = n_load;
    send_frame({16{8'hFF}}, {72{8'hEE}}, 8'h03);
    total++; if ({frame_err, load_en, busy} !== 3'b100) begin $display("FAIL cost03_err: got %b want 100", {frame_err, load_en, busy}); bad++; end
    send_frame({16{8'hFF}}, {72{8'hEE}}, 8'h20);
    total++; if ({frame_err, load_en, busy} !== 3'b100) begin $display("FAIL cost20_err: got %b want 100", {frame_err, load_en, busy}); bad++; end
    @(posedge clk); #1;
    total++; if (frame_err !== 1'b0) begin $display("FAIL cost_err_width: got %b want 0", frame_err); bad++; end
    total++; if (salt_c !== rep_salt(fa_salt) || key_c !== fa_key || cost !== 5'd10) begin $display("FAIL cost_err_hold: got cost %0d want 10 with prior salt/key", cost); bad++; end
    total++; if (n_err - e0 !== 2 || n_load - l0 !== 0) begin $display("FAIL cost_err_count: got err %0d load %0d want 2 0", n_err - e0, n_load - l0); bad++; end
  endtask

  task automatic test_junk_header();
    int e0;
    e0 = n_err;
    send_byte(8'h00);
    total++; if (frame_err !== 1'b1) begin $display("FAIL junk00_err: got %b want 1", frame_err); bad++; end
    send_byte(8'h7F);
    total++; if (frame_err !== 1'b1) begin $display("FAIL junk7f_err: got %b want 1", frame_err); bad++; end
    send_frame(fb_salt, fb_key, 8'h04);
    total++; if (load_en !== 1'b1 || cost !== 5'd4) begin $display("FAIL junk_load: got load %b cost %0d want 1 4", load_en, cost); bad++; end
    total++; if (salt_c !== rep_salt(fb_salt) || key_c !== fb_key) begin $display("FAIL junk_data: got %h want %h", salt_c, rep_salt(fb_salt)); bad++; end
    total++; if (n_err - e0 !== 2) begin $display("FAIL junk_err_count: got %0d want 2", n_err - e0); bad++; end
    finish_run();
  endtask

  task automatic test_timeout();
    int e0;
    send_byte(8'hA5);
    for (int i = 0; i < 16; i++) send_byte(fa_salt[127-8*i -: 8]);
    for (int i = 0; i < 40; i++) send_byte(fa_key[575-8*i -: 8]);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      total++; if (frame_err !== (k == 8)) begin $display("FAIL timeout_cycle%0d: got %b want %b", k, frame_err, k == 8); bad++; end
    end
    send_byte(8'h00);
    total++; if (frame_err !== 1'b1) begin $display("FAIL timeout_idle: got %b want 1", frame_err); bad++; end
    @(posedge clk); #1;
    e0 = n_err;
    send_byte(8'hA5);
    for (int i = 0; i < 16; i++) send_byte(fa_salt[127-8*i -: 8]);
    for (int i = 0; i < 40; i++) send_byte(fa_key[575-8*i -: 8]);
    repeat (7) begin @(posedge clk); #1; end
    for (int i = 40; i < 72; i++) send_byte(fa_key[575-8*i -: 8]);
    send_byte(8'h1F);
    total++; if (load_en !== 1'b1 || cost !== 5'd31 || key_c !== fa_key) begin $display("FAIL timeout_suppress_load: got load %b cost %0d want 1 31", load_en, cost); bad++; end
    @(posedge clk); #1;
    total++; if (n_err - e0 !== 0) begin $display("FAIL timeout_suppress_err: got %0d want 0", n_err - e0); bad++; end
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
  endtask

  task automatic test_run_hold();
    int e0;
    send_frame(fa_salt, fa_key, 8'h0A);
    e0 = n_err;
    rx_data = 8'hA5; rx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      total++; if (rx_ready !== 1'b0 || busy !== 1'b1) begin $display("FAIL hold_run%0d: got ready %b busy %b want 0 1", k, rx_ready, busy); bad++; end
    end
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    total++; if (rx_ready !== 1'b1 || busy !== 1'b0) begin $display("FAIL hold_after_done: got ready %b busy %b want 1 0", rx_ready, busy); bad++; end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    send_body(fb_salt, fb_key, 8'h0B);
    total++; if (load_en !== 1'b1 || cost !== 5'd11 || salt_c !== rep_salt(fb_salt)) begin $display("FAIL hold_reload: got load %b cost %0d want 1 11", load_en, cost); bad++; end
    total++; if (n_err - e0 !== 0) begin $display("FAIL hold_err: got %0d want 0", n_err - e0); bad++; end
    finish_run();
  endtask

  task automatic test_reset_mid();
    int l0, s0;
    send_byte(8'hA5);
    for (int i = 0; i < 16; i++) send_byte(fa_salt[127-8*i -: 8]);
    for (int i = 0; i < 20; i++) send_byte(fa_key[575-8*i -: 8]);
    reset_l = 1'b0;
    #2;
    total++; if (salt_c !== '0 || key_c !== '0 || cost !== 5'd0) begin $display("FAIL rstmid_outputs: got cost %0d want 0 and zero salt/key", cost); bad++; end
    total++; if (rx_ready !== 1'b1 || busy !== 1'b0) begin $display("FAIL rstmid_state: got ready %b busy %b want 1 0", rx_ready, busy); bad++; end
    @(negedge clk);
    reset_l = 1'b1;
    l0 = n_load; s0 = n_start;
    send_byte(8'hA5);
    for (int i = 0; i < 16; i++) send_byte(fb_salt[127-8*i -: 8]);
    for (int i = 0; i < 72; i++) send_byte(fb_key[575-8*i -: 8]);
    total++; if (salt_c !== '0 || cost !== 5'd0 || n_load - l0 !== 0) begin $display("FAIL rstmid_precost: got cost %0d loads %0d want 0 0", cost, n_load - l0); bad++; end
    send_byte(8'h07);
    total++; if (load_en !== 1'b1 || cost !== 5'd7 || key_c !== fb_key) begin $display("FAIL rstmid_load: got load %b cost %0d want 1 7", load_en, cost); bad++; end
    finish_run();
    total++; if (n_load - l0 !== 1 || n_start - s0 !== 1) begin $display("FAIL rstmid_pairs: got %0d %0d want 1 1", n_load - l0, n_start - s0); bad++; end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) fa_salt[127-8*i -: 8] = 8'(i);
    for (int i = 0; i < 72; i++) fa_key[575-8*i -: 8] = 8'(16 + i);
    fb_salt = 128'hFEDCBA98765432100123456789ABCDEF;
    fb_key  = ~fa_key;
    test_reset();
    test_good_frame();
    test_bad_cost();
    test_junk_header();
    test_timeout();
    test_run_hold();
    test_reset_mid();
    @(posedge clk); #1;
    total++; if (n_overlap !== 0) begin $display("FAIL pulse_overlap: got %0d want 0", n_overlap); bad++; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
